// File: rtl/cpu_pkg.sv
// Shared memory-access types: access sizes, back-end FSM states, the latched
// request payload and the load-extension helper.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_SIZE_NONE = 2'd0,
    MEM_SIZE_BYTE = 2'd1,
    MEM_SIZE_HALF = 2'd2,
    MEM_SIZE_WORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } dmi_state_t;

  // Request as captured in the accept cycle.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_t       size;
    logic            store;
    logic            sgn;
  } mem_req_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [2:0] size_bytes(input mem_size_t s);
    logic [2:0] n;
    case (s)
      MEM_SIZE_BYTE: n = 3'd1;
      MEM_SIZE_HALF: n = 3'd2;
      MEM_SIZE_WORD: n = 3'd4;
      default:       n = 3'd0;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend assembled load data; words pass through untouched.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                  input mem_size_t       s,
                                                  input logic            sgn);
    logic [XLEN-1:0] r;
    case (s)
      MEM_SIZE_BYTE: r = {{24{sgn & d[7]}}, d[7:0]};
      MEM_SIZE_HALF: r = {{16{sgn & d[15]}}, d[15:0]};
      MEM_SIZE_WORD: r = d;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_memory_interface_if.sv
// Word-wide data bus between the memory-access back end (master) and memory
// (slave). bus_rdata is valid in the bus_ack cycle; ack may coincide with req.
interface data_memory_interface_if;
  import cpu_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [NLANES-1:0] bus_wstrb;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/byte_lane_aligner.sv
// Combinational byte-lane steering for one bus transaction of a possibly split
// access.
//   off, nbytes : byte offset in the word and access size in bytes
//   phase       : 0 for the first transaction, 1 for the second of a split
//   lane_mask   : bus lanes touched in this phase
//   store_rot   : store data rotated left by off bytes (lane-positioned)
//   load_rot    : read data rotated right by off bytes (result-positioned)
//   load_mask   : result bytes supplied by this phase
//   split       : access crosses a word boundary
module byte_lane_aligner
  import cpu_pkg::*;
(
  input  logic [1:0]        off,
  input  logic [2:0]        nbytes,
  input  logic              phase,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [NLANES-1:0] lane_mask,
  output logic [XLEN-1:0]   store_rot,
  output logic [XLEN-1:0]   load_rot,
  output logic [NLANES-1:0] load_mask,
  output logic              split
);

  logic [3:0] off4;
  logic [3:0] end4;
  logic [3:0] base4;

  assign off4  = {2'b00, off};
  assign end4  = off4 + {1'b0, nbytes};
  assign base4 = phase ? 4'd4 : 4'd0;
  assign split = end4 > 4'd4;

  // Lane i of this phase carries access byte position base+i.
  always_comb begin
    lane_mask = '0;
    load_mask = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      lane_mask[i] = ((base4 + 4'(i)) >= off4) && ((base4 + 4'(i)) < end4);
      load_mask[i] = (4'(i) < {1'b0, nbytes}) &&
                     ((off4 + 4'(i)) >= base4) && ((off4 + 4'(i)) < (base4 + 4'd4));
    end
  end

  // Byte rotation is the same in both phases because ACC1 is exactly one word up.
  always_comb begin
    case (off)
      2'd1:    store_rot = {store_data[23:0], store_data[31:24]};
      2'd2:    store_rot = {store_data[15:0], store_data[31:16]};
      2'd3:    store_rot = {store_data[7:0],  store_data[31:8]};
      default: store_rot = store_data;
    endcase
    case (off)
      2'd1:    load_rot = {rdata[7:0],  rdata[31:8]};
      2'd2:    load_rot = {rdata[15:0], rdata[31:16]};
      2'd3:    load_rot = {rdata[23:0], rdata[31:24]};
      default: load_rot = rdata;
    endcase
  end

endmodule

// File: rtl/data_memory_interface.sv
// Memory-access stage back end: runs one load/store request on the word bus,
// splitting boundary-crossing accesses into two transactions.
//   clk, rst                 : clock, asynchronous active-low reset
//   memory_ready/address/... : request from the control section
//   memory_wait              : request in flight (combinational)
//   memory_valid             : one-cycle completion pulse
//   memory_data_load         : extended load result, held until the next load
//   mem_bus                  : word-wide data bus (master side)
module data_memory_interface
  import cpu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memory_ready,
  input  logic [XLEN-1:0]          memory_address,
  input  logic [XLEN-1:0]          memory_data_store,
  input  logic [1:0]               memory_read,
  input  logic [1:0]               memory_write,
  input  logic                     memory_load_signed,
  output logic                     memory_wait,
  output logic                     memory_valid,
  output logic [XLEN-1:0]          memory_data_load,
  data_memory_interface_if.master  mem_bus
);

  dmi_state_t        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [XLEN-1:0]   load_q, load_d;

  logic [NLANES-1:0] lane_mask;
  logic [NLANES-1:0] load_mask;
  logic [XLEN-1:0]   store_rot;
  logic [XLEN-1:0]   load_rot;
  logic [XLEN-1:0]   merged;
  logic              split;
  logic [XLEN-1:0]   word_addr;
  mem_size_t         wr_size;
  mem_size_t         rd_size;

  assign word_addr = {req_q.addr[XLEN-1:2], 2'b00};
  assign wr_size   = mem_size_t'(memory_write);
  assign rd_size   = mem_size_t'(memory_read);

  byte_lane_aligner u_aligner (
    .off        (req_q.addr[1:0]),
    .nbytes     (size_bytes(req_q.size)),
    .phase      (state_q == ACC1),
    .store_data (req_q.data),
    .rdata      (mem_bus.bus_rdata),
    .lane_mask  (lane_mask),
    .store_rot  (store_rot),
    .load_rot   (load_rot),
    .load_mask  (load_mask),
    .split      (split)
  );

  // Assembly register with this phase's read bytes merged in.
  always_comb begin
    merged = asm_q;
    for (int unsigned k = 0; k < NLANES; k++) begin
      if (load_mask[k]) merged[8*k +: 8] = load_rot[8*k +: 8];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      asm_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      asm_q   <= asm_d;
      load_q  <= load_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    asm_d             = asm_q;
    load_d            = load_q;
    mem_bus.bus_req   = 1'b0;
    mem_bus.bus_we    = 1'b0;
    mem_bus.bus_addr  = '0;
    mem_bus.bus_wdata = '0;
    mem_bus.bus_wstrb = '0;
    memory_valid      = 1'b0;
    memory_wait       = 1'b0;

    case (state_q)
      IDLE: begin
        if (memory_ready) begin
          memory_wait = 1'b1;
          req_d.addr  = memory_address;
          req_d.data  = memory_data_store;
          req_d.store = (wr_size != MEM_SIZE_NONE);
          req_d.size  = (wr_size != MEM_SIZE_NONE) ? wr_size : rd_size;
          req_d.sgn   = memory_load_signed;
          asm_d       = '0;
          if (wr_size == MEM_SIZE_NONE && rd_size == MEM_SIZE_NONE) begin
            load_d  = '0;
            state_d = DONE;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0, ACC1: begin
        memory_wait       = 1'b1;
        mem_bus.bus_req   = 1'b1;
        mem_bus.bus_we    = req_q.store;
        mem_bus.bus_addr  = (state_q == ACC1) ? word_addr + 32'd4 : word_addr;
        mem_bus.bus_wdata = req_q.store ? store_rot : '0;
        mem_bus.bus_wstrb = req_q.store ? lane_mask : '0;
        if (mem_bus.bus_ack) begin
          if (!req_q.store) asm_d = merged;
          if (state_q == ACC0 && split) begin
            state_d = ACC1;
          end else begin
            state_d = DONE;
            if (!req_q.store) load_d = extend_load(merged, req_q.size, req_q.sgn);
          end
        end
      end
      DONE: begin
        memory_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign memory_data_load = load_q;

endmodule

// File: tb/tb_data_memory_interface.sv
module tb_data_memory_interface;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_ready;
  logic [31:0] memory_address;
  logic [31:0] memory_data_store;
  logic [1:0]  memory_read;
  logic [1:0]  memory_write;
  logic        memory_load_signed;
  logic        memory_wait;
  logic        memory_valid;
  logic [31:0] memory_data_load;

  data_memory_interface_if mem_bus ();

  data_memory_interface dut (
    .clk                (clk),
    .rst                (rst),
    .memory_ready       (memory_ready),
    .memory_address     (memory_address),
    .memory_data_store  (memory_data_store),
    .memory_read        (memory_read),
    .memory_write       (memory_write),
    .memory_load_signed (memory_load_signed),
    .memory_wait        (memory_wait),
    .memory_valid       (memory_valid),
    .memory_data_load   (memory_data_load),
    .mem_bus            (mem_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] mem [256];
  int          mem_wait = 0;
  int          wcnt = 0;
  txn_t        txq[$];

  // Ack and read data are set up on the falling edge, so they are stable at the next rising edge.
  always @(negedge clk) begin
    mem_bus.bus_ack   = mem_bus.bus_req && (wcnt == mem_wait);
    mem_bus.bus_rdata = mem[mem_bus.bus_addr[9:2]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      mem[8'h3F] = 32'h2211AAAA;  // 0x0FC
      mem[8'h40] = 32'hBBBB4433;  // 0x100
      mem[8'h80] = 32'h80112233;  // 0x200
      mem[8'h81] = 32'h000000C3;  // 0x204
      mem[8'hFF] = 32'h11223344;  // 0xFFFFFFFC
      mem[8'h00] = 32'h55667788;  // 0x000
      wcnt = 0;
    end else if (!mem_bus.bus_req) begin
      wcnt = 0;
    end else if (mem_bus.bus_ack) begin
      txn_t t;
      t.addr  = mem_bus.bus_addr;
      t.we    = mem_bus.bus_we;
      t.strb  = mem_bus.bus_wstrb;
      t.wdata = mem_bus.bus_wdata;
      txq.push_back(t);
      if (mem_bus.bus_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_bus.bus_wstrb[b]) mem[mem_bus.bus_addr[9:2]][8*b +: 8] = mem_bus.bus_wdata[8*b +: 8];
      end
      wcnt = 0;
    end else begin
      wcnt = wcnt + 1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  typedef struct {
    logic [31:0] load;
    int          lat;
    int          acc;
  } sb_t;

  sb_t sbq[$];

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (memory_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 32'(memory_valid), 32'h0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("load_data", memory_data_load, e.load);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] rd,
                           input logic [1:0] wr, input logic sg, input logic [31:0] exp_load,
                           input int exp_lat, input bit push);
    sb_t e;
    @(negedge clk);
    memory_address     = a;
    memory_data_store  = d;
    memory_read        = rd;
    memory_write       = wr;
    memory_load_signed = sg;
    memory_ready       = 1'b1;
    e.load = exp_load;
    e.lat  = exp_lat;
    e.acc  = cyc;
    if (push) sbq.push_back(e);
    #1 chk("wait_on_accept", 32'(memory_wait), 32'h1);
    @(negedge clk);
    memory_ready = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no completion expected memory_valid", nm);
      sbq.delete();
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        sgn;
    int          wt;
    logic [31:0] exp_load;
    int          ntx;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] w1;
  } vec_t;

  localparam int NV = 24;
  vec_t vec [NV];

  initial begin
    int base;
    int lat;
    vec_t v;

    vec[0]  = '{32'h0FE, 32'h0, 2'd3, 2'd0, 1'b0, 0, 32'h44332211, 2, 32'h0FC, 4'h0, 32'h0, 32'h100, 4'h0, 32'h0};
    vec[1]  = '{32'h100, 32'hDEADBEEF, 2'd0, 2'd3, 1'b0, 0, 32'h44332211, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0};
    vec[2]  = '{32'h100, 32'h0, 2'd3, 2'd0, 1'b1, 0, 32'hDEADBEEF, 1, 32'h100, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[3]  = '{32'h203, 32'h0, 2'd1, 2'd0, 1'b1, 0, 32'hFFFFFF80, 1, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[4]  = '{32'h203, 32'h0, 2'd1, 2'd0, 1'b0, 0, 32'h00000080, 1, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[5]  = '{32'h202, 32'h0, 2'd2, 2'd0, 1'b1, 0, 32'hFFFF8011, 1, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[6]  = '{32'h201, 32'h0, 2'd2, 2'd0, 1'b0, 0, 32'h00001122, 1, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[7]  = '{32'h203, 32'h0, 2'd2, 2'd0, 1'b1, 0, 32'hFFFFC380, 2, 32'h200, 4'h0, 32'h0, 32'h204, 4'h0, 32'h0};
    vec[8]  = '{32'hFFFFFFFF, 32'h0000BEEF, 2'd0, 2'd2, 1'b0, 0, 32'hFFFFC380, 2, 32'hFFFFFFFC, 4'h8, 32'hEF000000, 32'h0, 4'h1, 32'h000000BE};
    vec[9]  = '{32'hFFFFFFFF, 32'h0, 2'd2, 2'd0, 1'b1, 0, 32'hFFFFBEEF, 2, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[10] = '{32'hFFFFFFFF, 32'h0, 2'd2, 2'd0, 1'b0, 0, 32'h0000BEEF, 2, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[11] = '{32'hFFFFFFFC, 32'h0, 2'd3, 2'd0, 1'b1, 0, 32'hEF223344, 1, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[12] = '{32'h000, 32'h0, 2'd3, 2'd0, 1'b0, 0, 32'h556677BE, 1, 32'h000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[13] = '{32'h123, 32'h12345678, 2'd0, 2'd0, 1'b1, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[14] = '{32'h201, 32'hFFFFFF5A, 2'd0, 2'd1, 1'b0, 0, 32'h0, 1, 32'h200, 4'h2, 32'h00005A00, 32'h0, 4'h0, 32'h0};
    vec[15] = '{32'h200, 32'h0, 2'd3, 2'd0, 1'b0, 0, 32'h80115A33, 1, 32'h200, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[16] = '{32'h202, 32'h12345678, 2'd0, 2'd3, 1'b0, 2, 32'h80115A33, 2, 32'h200, 4'hC, 32'h56780000, 32'h204, 4'h3, 32'h00001234};
    vec[17] = '{32'h202, 32'h0, 2'd3, 2'd0, 1'b0, 1, 32'h12345678, 2, 32'h200, 4'h0, 32'h0, 32'h204, 4'h0, 32'h0};
    vec[18] = '{32'h204, 32'h0, 2'd3, 2'd0, 1'b0, 0, 32'h00001234, 1, 32'h204, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[19] = '{32'h300, 32'hCAFEF00D, 2'd3, 2'd3, 1'b0, 0, 32'h00001234, 1, 32'h300, 4'hF, 32'hCAFEF00D, 32'h0, 4'h0, 32'h0};
    vec[20] = '{32'h300, 32'h0, 2'd3, 2'd0, 1'b0, 0, 32'hCAFEF00D, 1, 32'h300, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[21] = '{32'h301, 32'h0, 2'd1, 2'd0, 1'b0, 0, 32'h000000F0, 1, 32'h300, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[22] = '{32'h300, 32'h0, 2'd2, 2'd0, 1'b1, 0, 32'hFFFFF00D, 1, 32'h300, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vec[23] = '{32'h302, 32'h0, 2'd1, 2'd0, 1'b1, 0, 32'hFFFFFFFE, 1, 32'h300, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};

    rst                = 1'b0;
    memory_ready       = 1'b0;
    memory_address     = '0;
    memory_data_store  = '0;
    memory_read        = '0;
    memory_write       = '0;
    memory_load_signed = 1'b0;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_bus_req",   32'(mem_bus.bus_req),   32'h0);
    chk("rst_bus_we",    32'(mem_bus.bus_we),    32'h0);
    chk("rst_bus_addr",  mem_bus.bus_addr,       32'h0);
    chk("rst_bus_wdata", mem_bus.bus_wdata,      32'h0);
    chk("rst_bus_wstrb", 32'(mem_bus.bus_wstrb), 32'h0);
    chk("rst_valid",     32'(memory_valid),      32'h0);
    chk("rst_wait",      32'(memory_wait),       32'h0);
    chk("rst_load",      memory_data_load,       32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven requests.
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      mem_wait = v.wt;
      base = txq.size();
      lat = (v.ntx == 0) ? 1 : 1 + v.ntx * (1 + v.wt);
      start_req(v.addr, v.sdata, v.rd, v.wr, v.sgn, v.exp_load, lat, 1'b1);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_ntxn", i), 32'(txq.size() - base), 32'(v.ntx));
      if (v.ntx >= 1 && txq.size() >= base + 1) begin
        chk($sformatf("v%0d_t0_addr", i),  txq[base].addr, v.a0);
        chk($sformatf("v%0d_t0_we", i),    32'(txq[base].we), 32'(v.wr != 2'd0));
        chk($sformatf("v%0d_t0_strb", i),  32'(txq[base].strb), 32'(v.s0));
        chk($sformatf("v%0d_t0_wdata", i), txq[base].wdata & strb_mask(txq[base].strb), v.w0);
      end
      if (v.ntx == 2 && txq.size() >= base + 2) begin
        chk($sformatf("v%0d_t1_addr", i),  txq[base+1].addr, v.a1);
        chk($sformatf("v%0d_t1_strb", i),  32'(txq[base+1].strb), 32'(v.s1));
        chk($sformatf("v%0d_t1_wdata", i), txq[base+1].wdata & strb_mask(txq[base+1].strb), v.w1);
      end
    end

    // Aligned load with three wait cycles: bus held stable, latency 5.
    mem_wait = 3;
    base = txq.size();
    start_req(32'h200, 32'h0, 2'd3, 2'd0, 1'b0, 32'h56785A33, 5, 1'b1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("stall%0d_req", j),  32'(mem_bus.bus_req), 32'h1);
      chk($sformatf("stall%0d_addr", j), mem_bus.bus_addr, 32'h200);
      chk($sformatf("stall%0d_wait", j), 32'(memory_wait), 32'h1);
      @(negedge clk);
    end
    wait_done("stall");
    chk("stall_ntxn", 32'(txq.size() - base), 32'h1);

    // A second request while in ACC0 is ignored.
    mem_wait = 2;
    base = txq.size();
    start_req(32'h300, 32'h0, 2'd3, 2'd0, 1'b0, 32'hCAFEF00D, 4, 1'b1);
    memory_ready   = 1'b1;
    memory_address = 32'h0FE;
    memory_read    = 2'd3;
    @(negedge clk);
    @(negedge clk);
    memory_ready = 1'b0;
    wait_done("ignore");
    repeat (3) @(negedge clk);
    chk("ignore_ntxn", 32'(txq.size() - base), 32'h1);
    if (txq.size() >= base + 1) chk("ignore_addr", txq[base].addr, 32'h300);

    // Reset in ACC1 of a split load: bus drops at once, no completion.
    mem_wait = 1;
    start_req(32'h0FE, 32'h0, 2'd3, 2'd0, 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_acc1", 32'(dut.state_q), 32'(ACC1));
    rst = 1'b0;
    #1;
    chk("rst_mid_req",   32'(mem_bus.bus_req), 32'h0);
    chk("rst_mid_wait",  32'(memory_wait),     32'h0);
    chk("rst_mid_state", 32'(dut.state_q),     32'(IDLE));
    chk("rst_mid_load",  memory_data_load,     32'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_valid%0d", j), 32'(memory_valid), 32'h0);
    end
    rst = 1'b1;
    mem_wait = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(memory_valid), 32'h0);
    start_req(32'h0FE, 32'h0, 2'd3, 2'd0, 1'b0, 32'h44332211, 3, 1'b1);
    wait_done("post_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_interface.md
# data_memory_interface

Memory-access stage back end. Takes one load or store request from the control section's memory-access stage and runs it on a word-wide data bus. Handles byte, halfword and word sizes, builds write strobes, and sign- or zero-extends load data. A misaligned access that crosses a word boundary is split into two bus transactions.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.
- clk  in  1  clock. All state changes on its rising edge.
- rst  in  1  reset, active-low, asynchronous.
- memory_ready  in  1  request strobe from the control section.
- memory_address  in  32  byte address.
- memory_data_store  in  32  store data, least-significant-aligned.
- memory_read  in  2  load size: 0 none, 1 byte, 2 half, 3 word.
- memory_write  in  2  store size, same encoding as memory_read.
- memory_load_signed  in  1  1 sign-extends load data, 0 zero-extends it.
- memory_wait  out  1  request accepted and not yet complete.
- memory_valid  out  1  one-cycle completion pulse.
- memory_data_load  out  32  extended load data; valid while memory_valid=1.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write enable.
- bus_addr  out  32  word address; bits [1:0] are always 0.
- bus_wdata  out  32  write data, lane-positioned.
- bus_wstrb  out  4  byte strobes; bit i enables byte lane i.
- bus_rdata  in  32  read data; valid in the bus_ack cycle.
- bus_ack  in  1  transaction complete; may arrive in the same cycle as bus_req.

## Operation
- States:
  - IDLE: waiting for a request.
  - ACC0: first bus transaction.
  - ACC1: second bus transaction of a split access.
  - DONE: completion cycle.
- IDLE with memory_ready=1: latch address, store data, sizes and signedness.
  - memory_write≠0: the access is a store. The store wins over any read size.
  - Else memory_read≠0: the access is a load.
  - Else: no-op, go directly to DONE.
  - Otherwise go to ACC0.
- Define off = address[1:0] and nbytes = 1, 2 or 4. The access is split when off + nbytes > 4.
- ACC0:
  - bus_addr = {address[31:2], 2'b00}.
  - Active lanes are off .. min(off+nbytes-1, 3).
  - On bus_ack, go to ACC1 if split, else to DONE.
- ACC1:
  - bus_addr = ACC0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - Active lanes are 0 .. off+nbytes-5.
  - On bus_ack, go to DONE.
- Stores:
  - bus_wdata holds the store bytes rotated left by off bytes.
  - bus_wstrb = active lanes. Inactive lanes are don't-care in bus_wdata.
- Loads:
  - bus_wstrb = 0.
  - Bytes from active lanes are captured into an assembly register, in low-to-high order across ACC0 then ACC1.
  - In DONE, the result is extended from bit 8·nbytes−1 according to memory_load_signed. Word loads are not extended.
- DONE:
  - memory_valid=1 for exactly one cycle, then return to IDLE.
  - No-op requests return memory_data_load=0.
- memory_ready while not in IDLE is ignored. No queuing.

## Timing
- Reset values:
  - state IDLE.
  - bus_req, bus_we, memory_valid, memory_wait = 0.
  - bus_wstrb = 0, bus_addr = 0, bus_wdata = 0, memory_data_load = 0.
- memory_wait = (IDLE && memory_ready) || ACC0 || ACC1. It is combinational, so it rises in the accept cycle.
- bus_req = ACC0 || ACC1. bus_addr, bus_we, bus_wdata and bus_wstrb are held stable until bus_ack.
- Latency, counted from the accept edge to memory_valid, with zero-wait acks:
  - Aligned access: 2 cycles.
  - Split access: 3 cycles.
  - No-op: 1 cycle.
- Each bus wait cycle adds one cycle of latency.
- memory_data_load holds its value after DONE until the next load completes.
- Reset asserted mid-transaction:
  - bus_req drops immediately, with no clock edge required.
  - The partial load is discarded and no memory_valid is produced.
  - A split store may leave its first half written.

## Structure
- Shared package cpu_pkg holds:
  - mem_size_t, with MEM_SIZE_NONE/BYTE/HALF/WORD = 0..3.
  - dmi_state_t, with IDLE/ACC0/ACC1/DONE.
- Sub-module byte_lane_aligner is combinational. It covers:
  - Inputs: off, nbytes, phase.
  - Outputs: lane mask, store rotation, load-byte placement.
- FSM, latch registers and load assembly register stay in data_memory_interface.

## Test plan
- Word store 0xDEADBEEF to 0x100, ack in the same cycle → one transaction: bus_addr=0x100, bus_wstrb=4'b1111, bus_wdata=0xDEADBEEF. memory_valid 2 cycles after accept.
- Signed byte load from 0x203, bus_rdata=0x80xxxxxx → wstrb=0, memory_data_load=0xFFFFFF80. Repeat unsigned → 0x00000080.
- Word load from 0x0FE: first rdata=0x2211xxxx, second rdata=0xxxxx4433 → two transactions at 0x0FC then 0x100, memory_data_load=0x44332211, valid 3 cycles after accept.
- Halfword store 0xBEEF to 0xFFFFFFFF → transaction 1 at 0xFFFFFFFC with wstrb=4'b1000, lane 3=0xEF. Transaction 2 at 0x00000000 with wstrb=4'b0001, lane 0=0xBE.
- Aligned load with bus_ack delayed 3 cycles → bus_addr and bus_req held stable, memory_wait high throughout, memory_valid 5 cycles after accept.
- Second memory_ready while in ACC0 → ignored. rst low in ACC1 of a split load → bus_req 0 immediately, memory_valid never pulses, state IDLE.
